// File: rtl/xmss_hash_pkg.sv
// -----------------------------------------------------------------------------
// xmss_hash_pkg
// Shared definitions for the XMSS tweakable-hash block (thash_fh):
//   - default domain-separation padding values (F, H, PRF)
//   - keyAndMask address-word values used for key / bitmask derivation
//   - message_length encodings understood by the external sha256XMSS core
//   - FSM state encoding shared by the controller and the message formatter
//   - small helpers (saturating increment, hash-state decode)
// -----------------------------------------------------------------------------
package xmss_hash_pkg;

   // Default padding values (prepended as a KEY_LEN-bit big-endian integer)
   localparam int PAD_F_DEFAULT   = 0;
   localparam int PAD_H_DEFAULT   = 1;
   localparam int PAD_PRF_DEFAULT = 3;

   // keyAndMask values written into hash_addr[31:0]
   localparam logic [31:0] KAM_KEY = 32'd0;
   localparam logic [31:0] KAM_BM0 = 32'd1;
   localparam logic [31:0] KAM_BM1 = 32'd2;

   // message_length encodings
   localparam logic MSG_LEN_3N = 1'b0;
   localparam logic MSG_LEN_4N = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PRF_KEY = 3'd1,
      ST_PRF_BM0 = 3'd2,
      ST_PRF_BM1 = 3'd3,
      ST_HASH    = 3'd4,
      ST_FIN     = 3'd5
   } thash_state_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // True for the states that talk to the external hash core
   function automatic logic is_hash_state(input thash_state_t s);
      return (s == ST_PRF_KEY) || (s == ST_PRF_BM0) ||
             (s == ST_PRF_BM1) || (s == ST_HASH);
   endfunction

endpackage

// File: rtl/thash_fh_if.sv
// -----------------------------------------------------------------------------
// thash_fh_if
// Bundles the request side and the sha256XMSS core side of thash_fh.
//   slave  modport : the thash_fh block itself
//   master modport : the requester / core model (testbench or parent)
// Request side : start, mode, input_key, input_data, hash_addr ->
//                data_out, done, busy, hash_addr_updated
// Core side    : hash_start, hash_data_in, message_length ->
//                hash_done, hash_data_out
// -----------------------------------------------------------------------------
interface thash_fh_if #(
   parameter int KEY_LEN = 256
) ();
   logic                   start;
   logic                   mode;
   logic [KEY_LEN-1:0]     input_key;
   logic [2*KEY_LEN-1:0]   input_data;
   logic [255:0]           hash_addr;
   logic [KEY_LEN-1:0]     data_out;
   logic                   done;
   logic                   busy;
   logic [255:0]           hash_addr_updated;
   logic                   hash_start;
   logic [4*KEY_LEN-1:0]   hash_data_in;
   logic                   message_length;
   logic                   hash_done;
   logic [KEY_LEN-1:0]     hash_data_out;

   modport slave (
      input  start, mode, input_key, input_data, hash_addr,
      input  hash_done, hash_data_out,
      output data_out, done, busy, hash_addr_updated,
      output hash_start, hash_data_in, message_length
   );

   modport master (
      output start, mode, input_key, input_data, hash_addr,
      output hash_done, hash_data_out,
      input  data_out, done, busy, hash_addr_updated,
      input  hash_start, hash_data_in, message_length
   );
endinterface

// File: rtl/thash_fh_msg_fmt.sv
// -----------------------------------------------------------------------------
// thash_fh_msg_fmt
// Combinational assembly of the message presented to the sha256XMSS core.
//   state          : controller state (selects PRF key / bm0 / bm1 / final)
//   mode           : 0 = thash_f, 1 = thash_h
//   seed           : latched public seed
//   data           : latched message blocks {block0, block1}
//   addr           : latched XMSS address
//   dkey/bm0/bm1   : derived key and bitmasks
//   hash_data_in   : 4*KEY_LEN message, MSB-first, left-aligned
//   message_length : MSG_LEN_3N / MSG_LEN_4N
// 3*KEY_LEN messages sit in the top bits; the bottom KEY_LEN bits are zero.
// -----------------------------------------------------------------------------
module thash_fh_msg_fmt
   import xmss_hash_pkg::*;
#(
   parameter int KEY_LEN = 256,
   parameter int PAD_F   = PAD_F_DEFAULT,
   parameter int PAD_H   = PAD_H_DEFAULT,
   parameter int PAD_PRF = PAD_PRF_DEFAULT
) (
   input  thash_state_t           state,
   input  logic                   mode,
   input  logic [KEY_LEN-1:0]     seed,
   input  logic [2*KEY_LEN-1:0]   data,
   input  logic [255:0]           addr,
   input  logic [KEY_LEN-1:0]     dkey,
   input  logic [KEY_LEN-1:0]     bm0,
   input  logic [KEY_LEN-1:0]     bm1,
   output logic [4*KEY_LEN-1:0]   hash_data_in,
   output logic                   message_length
);

   localparam logic [KEY_LEN-1:0] PAD_F_N   = KEY_LEN'(PAD_F);
   localparam logic [KEY_LEN-1:0] PAD_H_N   = KEY_LEN'(PAD_H);
   localparam logic [KEY_LEN-1:0] PAD_PRF_N = KEY_LEN'(PAD_PRF);
   localparam logic [KEY_LEN-1:0] ZERO_N    = {KEY_LEN{1'b0}};

   // Address copies with keyAndMask = 0 / 1 / 2, fitted to KEY_LEN bits
   logic [255:0]       addr_kam [3];
   logic [KEY_LEN-1:0] addr_n   [3];

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_kam
         assign addr_kam[gi] = {addr[255:32], 32'(gi)};
         if (KEY_LEN == 256) begin : g_eq
            assign addr_n[gi] = addr_kam[gi];
         end else if (KEY_LEN > 256) begin : g_wide
            assign addr_n[gi] = {{(KEY_LEN-256){1'b0}}, addr_kam[gi]};
         end else begin : g_narrow
            assign addr_n[gi] = addr_kam[gi][KEY_LEN-1:0];
         end
      end
   endgenerate

   logic [KEY_LEN-1:0] blk0_masked;
   logic [KEY_LEN-1:0] blk1_masked;

   assign blk0_masked = data[2*KEY_LEN-1:KEY_LEN] ^ bm0;
   assign blk1_masked = data[KEY_LEN-1:0]         ^ bm1;

   always_comb begin
      hash_data_in   = '0;
      message_length = MSG_LEN_3N;
      case (state)
         ST_PRF_KEY: hash_data_in = {PAD_PRF_N, seed, addr_n[0], ZERO_N};
         ST_PRF_BM0: hash_data_in = {PAD_PRF_N, seed, addr_n[1], ZERO_N};
         ST_PRF_BM1: hash_data_in = {PAD_PRF_N, seed, addr_n[2], ZERO_N};
         ST_HASH: begin
            if (mode) begin
               hash_data_in   = {PAD_H_N, dkey, blk0_masked, blk1_masked};
               message_length = MSG_LEN_4N;
            end else begin
               hash_data_in   = {PAD_F_N, dkey, blk0_masked, ZERO_N};
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/thash_fh.sv
// -----------------------------------------------------------------------------
// thash_fh
// XMSS tweakable hash controller (thash_f / thash_h) driving an external
// sha256XMSS core. Sequence: PRF key -> PRF bitmask0 -> [PRF bitmask1] -> hash.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : thash_fh_if.slave (request side + core side)
//   perf_cycles (only with THASH_FH_PERF_CNT_EN defined): cycles from the
//               accepted start through done, inclusive; saturating.
// Every hash state has a one-cycle issue phase (hash_start high) followed by
// a wait phase that ends on hash_done; hash_done in any other cycle is ignored.
// -----------------------------------------------------------------------------
module thash_fh
   import xmss_hash_pkg::*;
#(
   parameter int KEY_LEN               = 256,
   parameter int XMSS_HASH_PADDING_F   = PAD_F_DEFAULT,
   parameter int XMSS_HASH_PADDING_H   = PAD_H_DEFAULT,
   parameter int XMSS_HASH_PADDING_PRF = PAD_PRF_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   thash_fh_if.slave   bus
`ifdef THASH_FH_PERF_CNT_EN
   ,
   output logic [31:0] perf_cycles
`endif
);

   thash_state_t         state_reg, state_next;
   logic                 issue_reg, issue_next;

   logic                 mode_reg;
   logic [KEY_LEN-1:0]   seed_reg;
   logic [2*KEY_LEN-1:0] data_reg;
   logic [255:0]         addr_reg;
   logic [KEY_LEN-1:0]   dkey_reg;
   logic [KEY_LEN-1:0]   bm0_reg;
   logic [KEY_LEN-1:0]   bm1_reg;
   logic [KEY_LEN-1:0]   data_out_reg;
   logic [255:0]         addr_upd_reg;

   logic                 accept;
   logic                 in_hash;
   logic                 result_valid;
   logic [4*KEY_LEN-1:0] msg;
   logic                 msg_len;

   assign accept       = (state_reg == ST_IDLE) && bus.start;
   assign in_hash      = is_hash_state(state_reg);
   assign result_valid = in_hash && !issue_reg && bus.hash_done;

   // ---------------------------------------------------------------- FSM ---
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         issue_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         issue_reg <= issue_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      issue_next = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.start) begin
               state_next = ST_PRF_KEY;
               issue_next = 1'b1;
            end
         end
         ST_PRF_KEY, ST_PRF_BM0, ST_PRF_BM1: begin
            if (result_valid) begin
               issue_next = 1'b1;
               case (state_reg)
                  ST_PRF_KEY: state_next = ST_PRF_BM0;
                  ST_PRF_BM0: state_next = mode_reg ? ST_PRF_BM1 : ST_HASH;
                  default:    state_next = ST_HASH;
               endcase
            end
         end
         ST_HASH: begin
            if (result_valid) begin
               state_next = ST_FIN;
            end
         end
         ST_FIN:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------- datapath ---
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_reg     <= 1'b0;
         seed_reg     <= '0;
         data_reg     <= '0;
         addr_reg     <= '0;
         dkey_reg     <= '0;
         bm0_reg      <= '0;
         bm1_reg      <= '0;
         data_out_reg <= '0;
         addr_upd_reg <= '0;
      end else begin
         if (accept) begin
            mode_reg <= bus.mode;
            seed_reg <= bus.input_key;
            data_reg <= bus.input_data;
            addr_reg <= bus.hash_addr;
         end
         if (result_valid) begin
            case (state_reg)
               ST_PRF_KEY: dkey_reg <= bus.hash_data_out;
               ST_PRF_BM0: bm0_reg  <= bus.hash_data_out;
               ST_PRF_BM1: bm1_reg  <= bus.hash_data_out;
               ST_HASH: begin
                  data_out_reg <= bus.hash_data_out;
                  // The address reported back carries the last keyAndMask used
                  addr_upd_reg <= {addr_reg[255:32], mode_reg ? KAM_BM1 : KAM_BM0};
               end
               default: ;
            endcase
         end
      end
   end

   thash_fh_msg_fmt #(
      .KEY_LEN (KEY_LEN),
      .PAD_F   (XMSS_HASH_PADDING_F),
      .PAD_H   (XMSS_HASH_PADDING_H),
      .PAD_PRF (XMSS_HASH_PADDING_PRF)
   ) u_msg_fmt (
      .state          (state_reg),
      .mode           (mode_reg),
      .seed           (seed_reg),
      .data           (data_reg),
      .addr           (addr_reg),
      .dkey           (dkey_reg),
      .bm0            (bm0_reg),
      .bm1            (bm1_reg),
      .hash_data_in   (msg),
      .message_length (msg_len)
   );

   assign bus.hash_start        = in_hash && issue_reg;
   assign bus.hash_data_in      = msg;
   assign bus.message_length    = msg_len;
   assign bus.busy              = (state_reg != ST_IDLE);
   assign bus.done              = (state_reg == ST_FIN);
   assign bus.data_out          = data_out_reg;
   assign bus.hash_addr_updated = addr_upd_reg;

`ifdef THASH_FH_PERF_CNT_EN
   // cnt_reg holds the number of cycles elapsed so far including the current
   // one; the accept cycle and the first busy cycle give the starting value 2.
   // perf_reg is loaded on entry to FIN so it already includes the done cycle.
   logic [31:0] cnt_reg;
   logic [31:0] perf_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg  <= '0;
         perf_reg <= '0;
      end else begin
         if (accept) begin
            cnt_reg <= 32'd2;
         end else if (state_reg != ST_IDLE) begin
            cnt_reg <= sat_inc32(cnt_reg);
         end
         if (result_valid && (state_reg == ST_HASH)) begin
            perf_reg <= sat_inc32(cnt_reg);
         end
      end
   end

   assign perf_cycles = perf_reg;
`endif

endmodule

// File: tb/tb_thash_fh.sv
// -----------------------------------------------------------------------------
// tb_thash_fh
// Bench for thash_fh with a behavioural sha256XMSS core stand-in (a fixed
// mixing function with configurable latency). Expected messages and results
// are derived from the thash_f / thash_h definitions in plain arithmetic.
// -----------------------------------------------------------------------------
module tb_thash_fh;

   localparam int N = 256;

   logic clk;
   logic reset;

   thash_fh_if #(.KEY_LEN(N)) bus ();

`ifdef THASH_FH_PERF_CNT_EN
   logic [31:0] perf_cycles;
`endif

   thash_fh #(.KEY_LEN(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef THASH_FH_PERF_CNT_EN
      ,
      .perf_cycles (perf_cycles)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic           mode;
      logic [N-1:0]   key;
      logic [2*N-1:0] data;
      logic [255:0]   addr;
      int             lat;
      logic [N-1:0]   exp_out;
      logic [255:0]   exp_addr;
      int             exp_starts;
   } vec_t;

   int checks = 0;
   int errors = 0;

   int             core_lat = 1;
   logic [4*N-1:0] log_msg[$];
   logic           log_len[$];
   int             unstable = 0;
   logic [N-1:0]   last_result;

   logic [4*N-1:0] exp_msg[4];
   logic           exp_len[4];
   int             exp_n;

   // Stand-in digest: position-sensitive mix of the four words plus length
   function automatic logic [N-1:0] core_fn(input logic [4*N-1:0] m, input logic len);
      logic [N-1:0] r;
      r = m[4*N-1:3*N] * 256'd3 + m[3*N-1:2*N] * 256'd5 +
          m[2*N-1:N]   * 256'd7 + m[N-1:0]     * 256'd11;
      r = {r[N-14:0], r[N-1:N-13]} ^ (len ? 256'hA5 : 256'h5A);
      return r;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Software thash_f / thash_h: fills exp_msg/exp_len/exp_n, returns result
   task automatic model(input vec_t v, output logic [N-1:0] res, output logic [255:0] upd);
      logic [N-1:0] dk, bm0, bm1, b0, b1;
      b0 = v.data[2*N-1:N];
      b1 = v.data[N-1:0];
      exp_msg[0] = {256'd3, v.key, v.addr[255:32], 32'd0, 256'd0}; exp_len[0] = 1'b0;
      dk  = core_fn(exp_msg[0], 1'b0);
      exp_msg[1] = {256'd3, v.key, v.addr[255:32], 32'd1, 256'd0}; exp_len[1] = 1'b0;
      bm0 = core_fn(exp_msg[1], 1'b0);
      if (v.mode) begin
         exp_msg[2] = {256'd3, v.key, v.addr[255:32], 32'd2, 256'd0}; exp_len[2] = 1'b0;
         bm1 = core_fn(exp_msg[2], 1'b0);
         exp_msg[3] = {256'd1, dk, b0 ^ bm0, b1 ^ bm1}; exp_len[3] = 1'b1;
         exp_n = 4;
         res = core_fn(exp_msg[3], 1'b1);
         upd = {v.addr[255:32], 32'd2};
      end else begin
         exp_msg[2] = {256'd0, dk, b0 ^ bm0, 256'd0}; exp_len[2] = 1'b0;
         exp_msg[3] = '0; exp_len[3] = 1'b0;
         exp_n = 3;
         res = core_fn(exp_msg[2], 1'b0);
         upd = {v.addr[255:32], 32'd1};
      end
   endtask

   // Core model: records each hash_start, answers core_lat cycles later
   initial begin : core_model
      logic           pend;
      int             cnt;
      logic [4*N-1:0] pend_msg;
      logic           pend_len;
      logic [N-1:0]   pend_res;
      pend = 1'b0; cnt = 0; pend_msg = '0; pend_len = 1'b0; pend_res = '0;
      bus.hash_done     = 1'b0;
      bus.hash_data_out = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.hash_done = 1'b0;
         if (reset) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               cnt--;
               if (cnt == 0) begin
                  if (bus.hash_data_in !== pend_msg || bus.message_length !== pend_len)
                     unstable++;
                  bus.hash_done     = 1'b1;
                  bus.hash_data_out = pend_res;
                  pend = 1'b0;
               end
            end
            if (bus.hash_start) begin
               log_msg.push_back(bus.hash_data_in);
               log_len.push_back(bus.message_length);
               pend_msg = bus.hash_data_in;
               pend_len = bus.message_length;
               pend_res = core_fn(bus.hash_data_in, bus.message_length);
               cnt  = core_lat;
               pend = 1'b1;
            end
         end
      end
   end

   task automatic drive_req(input vec_t v);
      bus.mode       = v.mode;
      bus.input_key  = v.key;
      bus.input_data = v.data;
      bus.hash_addr  = v.addr;
      bus.start      = 1'b1;
   endtask

   task automatic run_op(input int id, input vec_t v);
      logic [N-1:0] r;
      logic [255:0] u;
      int cyc;
      int expc;
      model(v, r, u);
      core_lat = v.lat;
      @(posedge clk); #2;
      chk("done_single_pulse", 256'(bus.done), 256'd0);
      log_msg.delete(); log_len.delete(); unstable = 0;
      drive_req(v);
      cyc = 1;
      @(posedge clk); #2;
      bus.start      = 1'b0;
      // Scramble inputs: the DUT must work from its latched copies
      bus.input_key  = ~v.key;
      bus.input_data = ~v.data;
      bus.hash_addr  = ~v.addr;
      bus.mode       = ~v.mode;
      cyc = 2;
      chk("busy_after_start", 256'(bus.busy), 256'd1);
      chk("data_out_held", bus.data_out, last_result);
      while (!bus.done && cyc < 4000) begin
         @(posedge clk); #2;
         cyc++;
      end
      if (!bus.done) begin
         checks++; errors++;
         $display("FAIL done_timeout: op %0d got no done after %0d cycles, required done", id, cyc);
         return;
      end
      expc = v.mode ? 4*v.lat + 6 : 3*v.lat + 5;
      chk("op_cycles", 256'(cyc), 256'(expc));
      chk("data_out", bus.data_out, v.exp_out);
      chk("addr_updated", bus.hash_addr_updated, v.exp_addr);
`ifdef THASH_FH_PERF_CNT_EN
      chk("perf_cycles", 256'(perf_cycles), 256'(expc));
`endif
      chk("hash_start_count", 256'(log_msg.size()), 256'(v.exp_starts));
      for (int k = 0; k < exp_n && k < log_msg.size(); k++) begin
         for (int j = 0; j < 4; j++)
            chk($sformatf("msg%0d_word%0d", k, 3-j), log_msg[k][j*N +: N], exp_msg[k][j*N +: N]);
         chk($sformatf("msg%0d_len", k), 256'(log_len[k]), 256'(exp_len[k]));
      end
      chk("msg_stable", 256'(unstable), 256'd0);
      last_result = v.exp_out;
      $display("op %0d: mode=%0d lat=%0d cycles=%0d starts=%0d data_out=%0h",
               id, v.mode, v.lat, cyc, log_msg.size(), bus.data_out);
   endtask

   vec_t vecs[10];

   initial begin : main
      vec_t v;
      logic [N-1:0] r;
      logic [255:0] u;
      int dones;
      int cyc;

      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.mode       = 1'b0;
      bus.input_key  = '0;
      bus.input_data = '0;
      bus.hash_addr  = '0;
      last_result    = '0;

      // ---- vector table: directed corners first, then random ----
      vecs[0].mode = 1'b1; vecs[0].key = '0; vecs[0].data = '0; vecs[0].addr = '0; vecs[0].lat = 3;
      vecs[1].mode = 1'b0; vecs[1].key = '1; vecs[1].data = {rnd256(), rnd256()};
      vecs[1].addr = 256'h5; vecs[1].lat = 2;
      for (int i = 2; i < 10; i++) begin
         vecs[i].mode = 1'($urandom_range(0, 1));
         vecs[i].key  = rnd256();
         vecs[i].data = {rnd256(), rnd256()};
         vecs[i].addr = rnd256();
         vecs[i].lat  = int'($urandom_range(1, 6));
      end
      for (int i = 0; i < 10; i++) begin
         model(vecs[i], r, u);
         vecs[i].exp_out    = r;
         vecs[i].exp_addr   = u;
         vecs[i].exp_starts = vecs[i].mode ? 4 : 3;
      end

      // ---- reset state ----
      repeat (3) @(posedge clk);
      #2;
      chk("rst_busy", 256'(bus.busy), 256'd0);
      chk("rst_done", 256'(bus.done), 256'd0);
      chk("rst_hash_start", 256'(bus.hash_start), 256'd0);
      chk("rst_data_out", bus.data_out, 256'd0);
      chk("rst_addr_updated", bus.hash_addr_updated, 256'd0);
      #1 reset = 1'b0;

      // ---- table run (consecutive ops are back-to-back) ----
      for (int i = 0; i < 10; i++) run_op(i, vecs[i]);

      // ---- start held high for 50 cycles during one operation ----
      v.mode = 1'b1; v.key = rnd256(); v.data = {rnd256(), rnd256()}; v.addr = rnd256(); v.lat = 15;
      model(v, r, u);
      core_lat = v.lat;
      @(posedge clk); #2;
      log_msg.delete(); log_len.delete();
      drive_req(v);
      dones = 0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #2;
         if (bus.done) dones++;
      end
      bus.start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #2;
         if (bus.done) dones++;
      end
      chk("held_start_done_count", 256'(dones), 256'd1);
      chk("held_start_start_count", 256'(log_msg.size()), 256'd4);
      chk("held_start_data_out", bus.data_out, r);
      last_result = r;
      $display("op held_start: done pulses=%0d starts=%0d data_out=%0h", dones, log_msg.size(), bus.data_out);

      // ---- reset during PRF_BM0 wait phase ----
      v.mode = 1'b1; v.key = rnd256(); v.data = {rnd256(), rnd256()}; v.addr = rnd256(); v.lat = 6;
      core_lat = v.lat;
      @(posedge clk); #2;
      log_msg.delete(); log_len.delete();
      drive_req(v);
      @(posedge clk); #2;
      bus.start = 1'b0;
      cyc = 0;
      while (log_msg.size() < 2 && cyc < 200) begin
         @(posedge clk); #2;
         cyc++;
      end
      chk("bm0_issue_reached", 256'(log_msg.size()), 256'd2);
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      chk("midrst_busy", 256'(bus.busy), 256'd0);
      chk("midrst_done", 256'(bus.done), 256'd0);
      chk("midrst_hash_start", 256'(bus.hash_start), 256'd0);
      chk("midrst_data_out", bus.data_out, 256'd0);
      chk("midrst_addr_updated", bus.hash_addr_updated, 256'd0);
      $display("op mid_reset: busy=%0d done=%0d data_out=%0h", bus.busy, bus.done, bus.data_out);
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b0;
      last_result = '0;

      v.mode = 1'b1; v.key = rnd256(); v.data = {rnd256(), rnd256()}; v.addr = rnd256(); v.lat = 4;
      model(v, r, u);
      v.exp_out = r; v.exp_addr = u; v.exp_starts = 4;
      run_op(100, v);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
